// File: rtl/axi_pwm_lite_slave.sv
// AXI4-Lite slave with four 32-bit R/W registers driving a two-channel PWM.
// Period, duty and invert settings are shadowed at each counter wrap so that no period mixes settings.
module axi_pwm_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [1:0]                      pwm_out,
    output logic                            period_tick
);

    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]  awsel_q, awsel_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];

    logic [15:0] psc_q, psc_d, cnt_q, cnt_d, per_sh_q, per_sh_d;
    logic [15:0] duty0_sh_q, duty0_sh_d, duty1_sh_q, duty1_sh_d;
    logic [1:0]  inv_sh_q, inv_sh_d, pwm_q, pwm_d;
    logic        tick_q, tick_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [1:0]  csel;
    logic [31:0] cdata;
    logic [3:0]  cstrb;
    logic        en, cen, wrap, cmp0, cmp1;
    logic [15:0] prescale;
    logic        unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs  = awready_q & S_AXI_AWVALID;
    assign w_hs   = wready_q & S_AXI_WVALID;
    assign ar_hs  = arready_q & S_AXI_ARVALID;
    // A handshake in this cycle counts as held, so commit can coincide with capture.
    assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign csel   = aw_hs ? S_AXI_AWADDR[3:2] : awsel_q;
    assign cdata  = w_hs ? S_AXI_WDATA : wdata_q;
    assign cstrb  = w_hs ? S_AXI_WSTRB : wstrb_q;

    always_comb begin
        awready_d = S_AXI_AWVALID & ~awready_q & ~aw_held_q & ~bvalid_q;
        wready_d  = S_AXI_WVALID & ~wready_q & ~w_held_q & ~bvalid_q;
        aw_held_d = commit ? 1'b0 : (aw_held_q | aw_hs);
        w_held_d  = commit ? 1'b0 : (w_held_q | w_hs);
        awsel_d   = aw_hs ? S_AXI_AWADDR[3:2] : awsel_q;
        wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
        bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (cstrb[b]) begin
                    regs_d[csel][8*b +: 8] = cdata[8*b +: 8];
                end
            end
        end
        arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
        rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
        rdata_d   = ar_hs ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
    end

    assign en       = regs_q[0][0];
    assign prescale = regs_q[0][31:16];

    always_comb begin
        psc_d      = psc_q;
        cnt_d      = cnt_q;
        cen        = 1'b0;
        wrap       = 1'b0;
        per_sh_d   = per_sh_q;
        duty0_sh_d = duty0_sh_q;
        duty1_sh_d = duty1_sh_q;
        inv_sh_d   = inv_sh_q;
        if (!en) begin
            psc_d = '0;
            cnt_d = '0;
        end else begin
            cen   = (psc_q >= prescale);
            psc_d = cen ? 16'd0 : psc_q + 16'd1;
            if (cen && per_sh_q != 16'd0) begin
                if (cnt_q >= per_sh_q - 16'd1) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
        if (!en || wrap) begin
            per_sh_d   = regs_q[1][15:0];
            duty0_sh_d = regs_q[2][15:0];
            duty1_sh_d = regs_q[3][15:0];
            inv_sh_d   = regs_q[0][2:1];
        end
    end

    always_comb begin
        cmp0     = (per_sh_q != 16'd0) && (cnt_q < duty0_sh_q);
        cmp1     = (per_sh_q != 16'd0) && (cnt_q < duty1_sh_q);
        pwm_d[0] = en & (cmp0 ^ inv_sh_q[0]);
        pwm_d[1] = en & (cmp1 ^ inv_sh_q[1]);
        tick_d   = wrap;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awsel_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            psc_q      <= '0;
            cnt_q      <= '0;
            per_sh_q   <= '0;
            duty0_sh_q <= '0;
            duty1_sh_q <= '0;
            inv_sh_q   <= '0;
            pwm_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awsel_q    <= awsel_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            psc_q      <= psc_d;
            cnt_q      <= cnt_d;
            per_sh_q   <= per_sh_d;
            duty0_sh_q <= duty0_sh_d;
            duty1_sh_q <= duty1_sh_d;
            inv_sh_q   <= inv_sh_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign pwm_out       = pwm_q;
    assign period_tick   = tick_q;

endmodule

// File: doc/axi_pwm_lite_slave.md
# axi_pwm_lite_slave

AXI4-Lite slave peripheral answering the S00_AXI master transactions: four 32-bit read/write registers and a two-channel PWM generator driven from them. It sits behind the S00_AXI port at `S00_AXI_SLAVE_ADDRESS` in the block design. Every register reads back exactly what was written, so the standard write/read-compare exercise passes. Its PWM outputs go to board pins.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select register
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  reset; synchronous and active-low
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- pwm_out  out  2  PWM channel outputs
- period_tick  out  1  one-cycle pulse at each PWM period wrap

## Operation
- Register map (offset, all 32-bit R/W, full-width storage, reset 0):
  - 0x0 CTRL: [0] enable, [1] ch0 invert, [2] ch1 invert, [31:16] prescale
  - 0x4 PERIOD: [15:0] period
  - 0x8 DUTY0: [15:0] duty for channel 0
  - 0xC DUTY1: [15:0] duty for channel 1
- Unused bits are stored and read back unchanged.
- Write path: AW and W are captured independently into holding registers, in either order or together.
  - AWREADY pulses for one cycle when AWVALID is high and no address is held; WREADY does the same for W.
  - Once both are held, the target register is updated per WSTRB byte lanes, BVALID rises, and the holds clear.
  - No new AW or W is accepted while BVALID is high.
- Read path: ARREADY pulses for one cycle when ARVALID is high and RVALID is low. RDATA is the register at ARADDR[3:2], registered.
- PWM engine:
  - Prescaler counts 0..prescale; each wrap produces one count enable.
  - 16-bit counter cnt counts 0..P-1, where P is the shadow period.
  - Shadow period, duty0 and duty1 load from the registers at counter wrap, and also while enable=0.
  - pwm_out[n] = enable & ((cnt < duty_sh[n]) XOR invert[n]).
  - duty ≥ P: output constantly high (before invert). duty=0: constantly low.
  - P=0: cnt holds 0, outputs are 0^invert gated by enable, no period_tick.
  - enable=0: cnt and prescaler held at 0; pwm_out=0 regardless of invert; no tick.
  - period_tick is high for the cycle in which cnt wraps P-1→0 (on a count enable).

## Timing
- Reset values (ARESETN low at a clock edge): all AXI READY/VALID outputs 0; RDATA 0; all registers, shadows, counters 0; pwm_out 0; period_tick 0.
- Reset mid-transaction aborts it; holds and responses are cleared.
- AW and W in the same cycle: both READYs pulse in cycle N; the register updates and BVALID rises at edge N+1. BVALID holds until the BREADY cycle, then drops the next edge.
- AR in cycle N: RVALID and RDATA valid from edge N+1, held stable until RREADY.
- Read after write: the response returns the value committed by the completed B handshake.
- Read and write in the same cycle are independent; the write commit and read sample use pre-edge values.
- Register change reaches the PWM at the next wrap, so a period never carries mixed settings.
- Output latency: pwm_out and period_tick are registered, one cycle behind cnt.

## Test plan
- Write/readback: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0,0x4,0x8,0xC; each read returns the same value; every BRESP/RRESP is OKAY.
- Byte strobes: write 0xFFFFFFFF to 0x8, then 0x12345678 with WSTRB=4'b0101 → read 0xFF34FF78.
- Ordering: W presented 3 cycles before AW → exactly one BVALID, one cycle after AW accept. Hold BREADY low 5 cycles → BVALID stays high, no new WREADY.
- Duty: PERIOD=10, DUTY0=3, DUTY1=10, prescale=0, enable=1 → pwm_out[0] high 3 of every 10 cycles; pwm_out[1] constant high; period_tick every 10 cycles.
- Glitch-free update and invert: change DUTY0 3→7 mid-period → the current period stays at 3 high, the next is 7. Set invert0 → 7 low, 3 high.
- Edge cases: PERIOD=0 → no period_tick, pwm_out=0. Prescale=1 → period doubles to 20 cycles. Pulse ARESETN low mid-write → BVALID 0, registers 0.
